pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port s_valid, input, 1 bit: upstream word present.
REQ-005 The block SHALL have port s_data, input, WIDTH bits: upstream payload.
REQ-006 The block SHALL have port s_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 The block SHALL have port m_valid, output, 1 bit: m_data holds a valid word.
REQ-008 The block SHALL have port m_data, output, WIDTH bits: downstream payload, driven straight from a register.
REQ-009 The block SHALL have port m_ready, input, 1 bit: downstream consumes this cycle.
REQ-010 The block SHALL have port level, output, 2 bits: occupancy, 0 to 2.

Function
REQ-011 A transfer SHALL occur on a port only when valid and ready are both high at a rising clk edge.
REQ-012 The block SHALL hold two registers: main, which drives m_data, and skid, the overflow entry.
REQ-013 The state machine SHALL have states EMPTY (level 0), BUSY (level 1, main valid) and FULL (level 2, main and skid valid).
REQ-014 m_valid SHALL equal (state != EMPTY), and level SHALL equal the state occupancy.
REQ-015 s_ready SHALL equal (state != FULL) AND NOT reset; no combinational path from m_ready to s_ready is permitted.
REQ-016 From EMPTY: s_valid -> main<=s_data, go to BUSY; otherwise stay in EMPTY.
REQ-017 From BUSY, s_valid & m_ready: main<=s_data, stay in BUSY (throughput of 1 word/cycle).
REQ-018 From BUSY, s_valid & !m_ready: skid<=s_data, go to FULL.
REQ-019 From BUSY, !s_valid & m_ready: go to EMPTY.
REQ-020 From BUSY, neither: hold.
REQ-021 From FULL, m_ready: main<=skid, go to BUSY; no input is accepted, because s_ready=0.
REQ-022 From FULL, !m_ready: hold; main and skid SHALL remain stable.
REQ-023 Latency SHALL be 1 cycle: a word accepted at edge N appears on m_data after edge N when the block was EMPTY, or when it was BUSY and m_ready was high at edge N.
REQ-024 Word order SHALL be strictly FIFO; no word is dropped or duplicated.
REQ-025 m_data SHALL NOT change while m_valid=1 and m_ready=0.
REQ-026 m_ready asserted while EMPTY SHALL have no effect.
REQ-027 s_data SHALL be ignored when s_valid=0 or s_ready=0.

Reset
REQ-028 While reset=1 at a clk edge, the block SHALL set state=EMPTY and clear main and skid to 0.
REQ-029 Reset values SHALL be m_valid=0, m_data=0, level=0 and s_ready=0 (s_ready=1 from the first cycle after reset is released).
REQ-030 Reset asserted mid-operation, in BUSY or FULL, SHALL discard all held words with no partial transfer at that edge.

Structure
REQ-031 State encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) SHALL live in shared package ppt_pipe_pkg, together with the default WIDTH.
REQ-032 main and skid SHALL each be an instance of sub-module pipe_data_reg (WIDTH-bit register, synchronous active-high reset, load enable).
REQ-033 The FSM and the enable/mux logic SHALL live in pipe_skid_reg.

Verification
REQ-034 Reset: hold reset=1 for 3 cycles with s_valid=1, s_data=32'hFFFF_FFFF -> m_valid=0, m_data=0, level=0, s_ready=0 throughout.
REQ-035 Streaming: s_valid=1 and m_ready=1 continuously with s_data 1,2,3,...,16 -> m_data 1..16 in consecutive cycles, each 1 cycle after input, level=1 steady.
REQ-036 Backpressure: send 32'hA, then 32'hB, with m_ready=0 -> level 1 then 2, s_ready=0, m_data=32'hA stable; raise m_ready -> outputs A then B, level 2->1->0.
REQ-037 Stall-on-full: in FULL, hold s_valid=1 with s_data=32'hC for 4 cycles -> C is not accepted until s_ready=1; output order is A, B, C with no loss.
REQ-038 Mid-operation reset: reach FULL, assert reset for 1 cycle -> the next cycle shows level=0 and m_valid=0, and words A and B never appear.
REQ-039 Random: random s_valid/m_ready at 50% each for 10k cycles against a scoreboard queue -> exact order match, and m_data never changes while stalled.

Source files
------------

// File: rtl/ppt_pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register: FSM encoding
// and the default payload width.
package ppt_pipe_pkg;

  localparam int PPT_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Occupancy reported on the level port for each state.
  function automatic logic [1:0] state_level(input state_e st);
    case (st)
      ST_BUSY: state_level = 2'd1;
      ST_FULL: state_level = 2'd2;
      default: state_level = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable and synchronous clear.
module pipe_data_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register: full throughput, registered
// m_data, and s_ready that depends only on state (never on m_ready).
module pipe_skid_reg
  import ppt_pipe_pkg::*;
#(
  parameter int WIDTH = PPT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       level
);

  state_e           r_state;
  state_e           w_next;
  logic             w_main_load;
  logic             w_main_from_skid;
  logic             w_skid_load;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_skid_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (s_valid) w_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (s_valid && !m_ready)      w_next = ST_FULL;
        else if (!s_valid && m_ready) w_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (m_ready) w_next = ST_BUSY;
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  // Output and datapath-enable logic
  always_comb begin
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_main_load = s_valid;
      end
      ST_BUSY: begin
        w_main_load = s_valid && m_ready;
        w_skid_load = s_valid && !m_ready;
      end
      ST_FULL: begin
        // Skid drains into main; no input is taken in this state.
        w_main_load      = m_ready;
        w_main_from_skid = 1'b1;
      end
      default: ;
    endcase
    m_valid = (r_state != ST_EMPTY);
    level   = state_level(r_state);
  end

  assign s_ready  = (r_state != ST_FULL) && !reset;
  assign w_main_d = w_main_from_skid ? w_skid_q : s_data;

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (m_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_skid_load),
    .i_d    (s_data),
    .o_q    (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random
// traffic compared against a two-entry FIFO reference model.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic [1:0]  level;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] model_q[$];
  logic [31:0] out_log[$];
  logic        exp_zero = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .level   (level)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, clock, update model.
  task automatic cycle(input logic rst, input logic sv, input logic [31:0] sd, input logic mr);
    logic push;
    logic pop;
    reset = rst; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    check_eq("s_ready", {31'd0, s_ready}, {31'd0, (model_q.size() < 2) && !rst});
    check_eq("m_valid", {31'd0, m_valid}, {31'd0, model_q.size() != 0});
    check_eq("level", {30'd0, level}, 32'(model_q.size()));
    if (model_q.size() != 0) check_eq("m_data", m_data, model_q[0]);
    else if (exp_zero) check_eq("m_data_clr", m_data, 32'd0);
    if (prev_stall) check_eq("stall_hold", m_data, prev_data);
    if (m_valid && mr && !rst) out_log.push_back(m_data);
    prev_stall = (model_q.size() != 0) && !mr && !rst;
    prev_data  = m_data;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      exp_zero = 1'b1;
    end else begin
      pop  = mr && (model_q.size() != 0);
      push = sv && (model_q.size() < 2);
      if (pop) void'(model_q.pop_front());
      if (push) begin
        model_q.push_back(sd);
        exp_zero = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_q.delete();
    exp_zero = 1'b1;

    // Reset held with input activity
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // Streaming 1..16 at full rate
    out_log.delete();
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 32'(i), 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("stream_cnt", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < out_log.size() && i < 16; i++)
      check_eq("stream_word", out_log[i], 32'(i + 1));

    // Backpressure and stall-on-full
    out_log.delete();
    cycle(1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b0, 1'b1, 32'hB, 1'b0);
    check_eq("bp_level", {30'd0, level}, 32'd2);
    check_eq("bp_head", m_data, 32'hA);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'hC, 1'b0);
    cycle(1'b0, 1'b1, 32'hC, 1'b1);
    cycle(1'b0, 1'b1, 32'hC, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("bp_cnt", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      check_eq("bp_w0", out_log[0], 32'hA);
      check_eq("bp_w1", out_log[1], 32'hB);
      check_eq("bp_w2", out_log[2], 32'hC);
    end

    // Reset while FULL discards held words
    out_log.delete();
    cycle(1'b0, 1'b1, 32'hA, 1'b0);
    cycle(1'b0, 1'b1, 32'hB, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check_eq("mrst_level", {30'd0, level}, 32'd0);
    check_eq("mrst_valid", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("mrst_cnt", 32'(out_log.size()), 32'd0);

    // Random traffic
    for (int i = 0; i < 10000; i++)
      cycle(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
